// File: rtl/hqc_fft_pkg.sv
// Shared types and constants for the HQC decap additive-FFT feeder blocks.
package hqc_fft_pkg;

    localparam int FFT_N_COEF    = 32;
    localparam int FFT_COEF_W    = 8;
    localparam int FFT_OUT_WORDS = 8;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2
    } fft_ld_state_e;

    typedef logic [4:0] coef_idx_t;

    // Bit offset of coefficient idx in the packed word (coefficient 0 sits in the MSByte)
    function automatic logic [7:0] coef_lsb(input coef_idx_t idx);
        coef_idx_t pos;
        pos = 5'd31 - idx;
        return {pos, 3'b000};
    endfunction

endpackage

// File: rtl/fft_drain_tracker.sv
// Tracks whether the last FFT part 1 result is still waiting to be read out.
// A result is drained once done has been seen and N_OUT_WORDS reads followed
// (a read in the same cycle as done already counts).
module fft_drain_tracker
    import hqc_fft_pkg::*;
#(
    parameter int N_OUT_WORDS = FFT_OUT_WORDS
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic issue_i,
    input  logic done_i,
    input  logic read_i,
    output logic outstanding_o
);

    localparam int CNT_W = $clog2(N_OUT_WORDS + 1);

    logic             outstanding_r;
    logic             done_seen_r;
    logic [CNT_W-1:0] drain_cnt_r;
    logic             count_s;

    assign count_s       = read_i & outstanding_r & (done_seen_r | done_i);
    assign outstanding_o = outstanding_r;

    // Outstanding / done-seen / drain-count bookkeeping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_r <= 1'b0;
            done_seen_r   <= 1'b0;
            drain_cnt_r   <= '0;
        end else if (issue_i) begin
            outstanding_r <= 1'b1;
            done_seen_r   <= 1'b0;
            drain_cnt_r   <= '0;
        end else if (outstanding_r) begin
            if (done_i) begin
                done_seen_r <= 1'b1;
            end
            if (count_s) begin
                drain_cnt_r <= drain_cnt_r + CNT_W'(1);
                if (drain_cnt_r == CNT_W'(N_OUT_WORDS - 1)) begin
                    outstanding_r <= 1'b0;
                    done_seen_r   <= 1'b0;
                end
            end
        end else begin
            done_seen_r <= 1'b0;
        end
    end

endmodule

// File: rtl/fft_elp_loader.sv
// Byte-serial ELP coefficient collector feeding FFT part 1.
// Packs up to 32 coefficients (coef 0 in the MSByte, zero padded) and issues
// a one-cycle start once FFT part 1 is idle and its previous result drained.
// Optional: define FFT_ELP_LOADER_DEGREE_EN to track the ELP degree on deg_o.
module fft_elp_loader
    import hqc_fft_pkg::*;
#(
    parameter int N_COEF      = FFT_N_COEF,
    parameter int COEF_W      = FFT_COEF_W,
    parameter int N_OUT_WORDS = FFT_OUT_WORDS
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [COEF_W-1:0]          coef_i,
    input  logic                       coef_valid_i,
    input  logic                       coef_last_i,
    output logic                       coef_ready_o,
    output logic [N_COEF*COEF_W-1:0]   fft_din_o,
    output logic                       fft_start_o,
    input  logic                       fft_busy_i,
    input  logic                       fft_done_i,
    input  logic                       fft_dout_read_i,
    output logic                       busy_o,
    output logic [5:0]                 deg_o
);

    fft_ld_state_e             state_r;
    coef_idx_t                 idx_r;
    logic [N_COEF*COEF_W-1:0]  buf_r;
    logic                      coef_ready_r;
    logic                      fft_start_r;
    logic                      outstanding_s;
    logic                      accept_s;
    logic                      final_byte_s;

    assign accept_s     = (state_r == LOAD) & coef_ready_r & coef_valid_i;
    assign final_byte_s = coef_last_i | (idx_r == coef_idx_t'(N_COEF - 1));

    assign coef_ready_o = coef_ready_r;
    assign fft_start_o  = fft_start_r;
    assign fft_din_o    = buf_r;
    assign busy_o       = (state_r != LOAD) | outstanding_s;

`ifdef FFT_ELP_LOADER_DEGREE_EN
    logic [5:0] deg_r;
    assign deg_o = deg_r;

    // Degree = index of the most recent nonzero coefficient (indices only grow)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            deg_r <= 6'd0;
        end else if (state_r == ISSUE) begin
            deg_r <= 6'd0;
        end else if (accept_s && (coef_i != '0)) begin
            deg_r <= {1'b0, idx_r};
        end else begin
            deg_r <= deg_r;
        end
    end
`else
    assign deg_o = 6'd0;
`endif

    // Load / wait / issue sequencing with registered handshake outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r      <= LOAD;
            idx_r        <= '0;
            buf_r        <= '0;
            coef_ready_r <= 1'b0;
            fft_start_r  <= 1'b0;
        end else begin
            case (state_r)
                LOAD: begin
                    coef_ready_r <= 1'b1;
                    fft_start_r  <= 1'b0;
                    if (accept_s) begin
                        buf_r[coef_lsb(idx_r) +: COEF_W] <= coef_i;
                        idx_r <= idx_r + 5'd1;
                        if (final_byte_s) begin
                            state_r      <= WAIT;
                            coef_ready_r <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    coef_ready_r <= 1'b0;
                    // outstanding is registered, so a final read lands one cycle later here
                    if (!outstanding_s && !fft_busy_i) begin
                        state_r     <= ISSUE;
                        fft_start_r <= 1'b1;
                    end else begin
                        fft_start_r <= 1'b0;
                    end
                end
                ISSUE: begin
                    // din was held through the start pulse; now clear for the next polynomial
                    fft_start_r  <= 1'b0;
                    buf_r        <= '0;
                    idx_r        <= '0;
                    state_r      <= LOAD;
                    coef_ready_r <= 1'b1;
                end
                default: begin
                    state_r      <= LOAD;
                    coef_ready_r <= 1'b0;
                    fft_start_r  <= 1'b0;
                end
            endcase
        end
    end

    fft_drain_tracker #(
        .N_OUT_WORDS (N_OUT_WORDS)
    ) u_drain (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .issue_i       (fft_start_r),
        .done_i        (fft_done_i),
        .read_i        (fft_dout_read_i),
        .outstanding_o (outstanding_s)
    );

endmodule
